flush_sched_ctrl: RTL and testbench
===================================

// Module: flush_sched_ctrl
// PURPOSE
//  Scheduler for the shared flush-water tank that feeds N washroom stalls.
//  - Captures per-stall flush requests and grants one flush valve at a time, round-robin.
//  - Runs the tank refill pump whenever the tank reports low.
//  - Raises an owner alert when a refill exceeds its timeout.
//  Sits between the per-stall smart-washroom units (flush buttons) and the tank valves/pump.
// PARAMETERS
//  N_STALLS       4   number of stalls/valves (>=2)
//  FLUSH_CYCLES   8   clocks each valve stays open (>=1)
//  REFILL_TIMEOUT 64  max clocks in REFILL before FAULT (>=1)
// PORTS
//  clk          in  1        system clock, rising edge
//  rst          in  1        asynchronous, active-high reset
//  flush_req    in  N_STALLS per-stall flush request; any cycle high = one request
//  tank_low     in  1        1 = tank below flush level
//  fault_clr    in  1        1-cycle pulse clears FAULT
//  valve_open   out N_STALLS one-hot flush valve enables, registered
//  grant_id     out clog2(N) index of last/current granted stall
//  pending      out N_STALLS requests captured, not yet served
//  refill_pump  out 1        pump enable, registered
//  busy         out 1        1 in FLUSH or REFILL
//  owner_alert  out 1        1 in FAULT
// BEHAVIOUR
//  Reset (async, rst=1):
//  - All outputs 0; state=IDLE; rr pointer=N_STALLS-1, so stall 0 wins first.
//  Capture:
//  - pending[i] <= pending[i] | flush_req[i] each edge.
//  - Cleared only on grant of stall i.
//  - flush_req[i] while stall i is being flushed is dropped, not re-queued.
//  FSM states: IDLE, FLUSH, REFILL, FAULT.
//  - IDLE, tank_low=1: -> REFILL. Tank refill has priority over any pending flush.
//  - IDLE, tank_low=0, pending!=0:
//    - Pick first set bit searching from rr+1 with wrap-around.
//    - Next edge: valve_open=onehot(g), grant_id=g, rr=g, pending[g] cleared, -> FLUSH.
//  - FLUSH: valve held exactly FLUSH_CYCLES cycles via down-counter.
//    - On last cycle: -> REFILL if tank_low=1, else IDLE.
//    - valve_open returns to 0 on the same edge.
//    - tank_low mid-flush never aborts the flush.
//  - REFILL: refill_pump=1, timeout counter increments each cycle.
//    - tank_low=0: -> IDLE, pump off on the next edge.
//    - Counter reaches REFILL_TIMEOUT: -> FAULT.
//  - FAULT: pump off, valves off, owner_alert=1.
//    - Requests still captured into pending.
//    - fault_clr=1 -> IDLE.
//  Latency:
//  - flush_req in cycle 0 -> pending=1 in cycle 1 -> valve_open in cycles 2..FLUSH_CYCLES+1.
//  - Minimum gap between two flushes is 1 IDLE cycle.
//  Simultaneous events:
//  - Same-cycle requests are served in rr order, one per flush slot.
//  - fault_clr outside FAULT is ignored.
//  - rst mid-flush closes the valve immediately and clears pending.
//  Invariants: valve_open is always one-hot or zero; valve_open and refill_pump are never both 1.
// CONFIGURATION
//  FLUSH_SCHED_STATS_EN defined:
//  - Adds output flush_count [15:0]: +1 per grant, saturates at 16'hFFFF, reset to 0.
//  - Adds output fault_count [7:0]: +1 per FAULT entry, saturating, reset to 0.
//  FLUSH_SCHED_STATS_EN undefined: neither port nor counter exists; the rest of the behaviour is identical.
// TESTING
//  1. Reset, then flush_req=4'b0100 for 1 cycle -> valve_open=4'b0100 for cycles 2..9, grant_id=2, pending back to 0.
//  2. flush_req=4'b1011 in one cycle -> grants in order 0, 1, 3; each valve open 8 cycles with a 1-cycle gap; never two valves at once.
//  3. tank_low=1 during stall 1 flush -> flush completes 8 cycles, then refill_pump=1 until tank_low=0; queued stall 2 flushes only after the pump is off.
//  4. tank_low held 1 for 64 REFILL cycles -> owner_alert=1, pump=0; fault_clr pulse -> IDLE, then REFILL again if tank_low is still 1.
//  5. rst asserted mid-flush on a non-clock edge -> all outputs 0 immediately, pending cleared; next grant goes to stall 0.
//  6. With FLUSH_SCHED_STATS_EN: 3 grants -> flush_count=3; preload near max -> count holds at 16'hFFFF.

Source files
------------

// File: rtl/flush_sched_if.sv
// Handshake bundle between the stall units, the flush scheduler and the tank valves/pump.
// Stats ports exist only when FLUSH_SCHED_STATS_EN is defined.
interface flush_sched_if #(
    parameter int N_STALLS = 4
) ();
    localparam int ID_W = (N_STALLS > 1) ? $clog2(N_STALLS) : 1;

    logic [N_STALLS-1:0] flush_req;
    logic                tank_low;
    logic                fault_clr;
    logic [N_STALLS-1:0] valve_open;
    logic [ID_W-1:0]     grant_id;
    logic [N_STALLS-1:0] pending;
    logic                refill_pump;
    logic                busy;
    logic                owner_alert;
`ifdef FLUSH_SCHED_STATS_EN
    logic [15:0]         flush_count;
    logic [7:0]          fault_count;
`endif

    modport master (
        output flush_req, tank_low, fault_clr,
        input  valve_open, grant_id, pending, refill_pump, busy, owner_alert
`ifdef FLUSH_SCHED_STATS_EN
        , input flush_count, fault_count
`endif
    );

    modport slave (
        input  flush_req, tank_low, fault_clr,
        output valve_open, grant_id, pending, refill_pump, busy, owner_alert
`ifdef FLUSH_SCHED_STATS_EN
        , output flush_count, fault_count
`endif
    );
endinterface

// File: rtl/flush_sched_ctrl.sv
// Round-robin flush valve scheduler with tank refill pump and refill-timeout fault.
// Define FLUSH_SCHED_STATS_EN to add saturating grant/fault counters.
module flush_sched_ctrl #(
    parameter int N_STALLS       = 4,
    parameter int FLUSH_CYCLES   = 8,
    parameter int REFILL_TIMEOUT = 64
) (
    input logic          clk,
    input logic          rst,
    flush_sched_if.slave bus
);
    localparam int ID_W = (N_STALLS > 1) ? $clog2(N_STALLS) : 1;
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int TO_W = (REFILL_TIMEOUT > 1) ? $clog2(REFILL_TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StFlush, StRefill, StFault} state_e;

    state_e              state_q, state_d;
    logic [N_STALLS-1:0] valve_q, valve_d;
    logic [N_STALLS-1:0] pending_q, pending_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [ID_W-1:0]     rr_q, rr_d;
    logic                pump_q, pump_d;
    logic [FC_W-1:0]     fcnt_q, fcnt_d;
    logic [TO_W-1:0]     tmo_q, tmo_d;

    logic                pick_valid;
    logic [ID_W-1:0]     pick_id;
    logic                grant_evt;
    logic                fault_evt;

    // Rotating priority: first pending stall strictly after the last grant.
    always_comb begin
        logic [ID_W-1:0] idx;
        pick_valid = 1'b0;
        pick_id    = '0;
        idx        = '0;
        for (int k = 1; k <= N_STALLS; k++) begin
            idx = ID_W'((int'(rr_q) + k) % N_STALLS);
            if (!pick_valid && pending_q[idx]) begin
                pick_valid = 1'b1;
                pick_id    = idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        valve_d   = valve_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        pump_d    = pump_q;
        fcnt_d    = fcnt_q;
        tmo_d     = tmo_q;
        grant_evt = 1'b0;
        fault_evt = 1'b0;
        // Requests from the stall currently being flushed are dropped.
        pending_d = pending_q | (bus.flush_req & ~valve_q);

        unique case (state_q)
            StIdle: begin
                if (bus.tank_low) begin
                    state_d = StRefill;
                    pump_d  = 1'b1;
                    tmo_d   = '0;
                end else if (pick_valid) begin
                    state_d            = StFlush;
                    valve_d            = {{(N_STALLS-1){1'b0}}, 1'b1} << pick_id;
                    grant_d            = pick_id;
                    rr_d               = pick_id;
                    pending_d[pick_id] = 1'b0;
                    fcnt_d             = FC_W'(FLUSH_CYCLES - 1);
                    grant_evt          = 1'b1;
                end
            end
            StFlush: begin
                if (fcnt_q == '0) begin
                    valve_d = '0;
                    if (bus.tank_low) begin
                        state_d = StRefill;
                        pump_d  = 1'b1;
                        tmo_d   = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    fcnt_d = fcnt_q - FC_W'(1);
                end
            end
            StRefill: begin
                if (!bus.tank_low) begin
                    state_d = StIdle;
                    pump_d  = 1'b0;
                end else if (tmo_q == TO_W'(REFILL_TIMEOUT - 1)) begin
                    state_d   = StFault;
                    pump_d    = 1'b0;
                    fault_evt = 1'b1;
                end else begin
                    tmo_d = tmo_q + TO_W'(1);
                end
            end
            StFault: begin
                if (bus.fault_clr) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            valve_q   <= '0;
            pending_q <= '0;
            grant_q   <= '0;
            rr_q      <= ID_W'(N_STALLS - 1);
            pump_q    <= 1'b0;
            fcnt_q    <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            valve_q   <= valve_d;
            pending_q <= pending_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            pump_q    <= pump_d;
            fcnt_q    <= fcnt_d;
            tmo_q     <= tmo_d;
        end
    end

    assign bus.valve_open  = valve_q;
    assign bus.grant_id    = grant_q;
    assign bus.pending     = pending_q;
    assign bus.refill_pump = pump_q;
    assign bus.busy        = (state_q == StFlush) || (state_q == StRefill);
    assign bus.owner_alert = (state_q == StFault);

`ifdef FLUSH_SCHED_STATS_EN
    logic [15:0] flush_count_q;
    logic [7:0]  fault_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_count_q <= '0;
            fault_count_q <= '0;
        end else begin
            if (grant_evt && (flush_count_q != 16'hFFFF)) begin
                flush_count_q <= flush_count_q + 16'd1;
            end
            if (fault_evt && (fault_count_q != 8'hFF)) begin
                fault_count_q <= fault_count_q + 8'd1;
            end
        end
    end

    assign bus.flush_count = flush_count_q;
    assign bus.fault_count = fault_count_q;
`else
    logic unused_evt;
    assign unused_evt = grant_evt ^ fault_evt;
`endif
endmodule

// File: tb/tb_flush_sched_ctrl.sv
// Self-checking bench for flush_sched_ctrl against a cycle-level behavioural model.
module tb_flush_sched_ctrl;
    localparam int N  = 4;
    localparam int FC = 8;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    flush_sched_if #(.N_STALLS(N)) bus ();

    flush_sched_ctrl #(
        .N_STALLS      (N),
        .FLUSH_CYCLES  (FC),
        .REFILL_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: which stall is flushing and for how long, refill age, fault flag.
    logic [N-1:0] m_pend;
    int m_flush, m_left, m_refill, m_age, m_fault, m_rr, m_grant, m_grants;

    function automatic logic [N-1:0] onehot(input int s);
        logic [N-1:0] one;
        one = 1;
        return one << s;
    endfunction

    function automatic logic [N-1:0] exp_valve();
        return (m_flush >= 0) ? onehot(m_flush) : '0;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_flush = -1; m_left = 0; m_refill = 0; m_age = 0;
        m_fault = 0; m_rr = N - 1; m_grant = 0; m_grants = 0;
    endtask

    task automatic model_step(input logic [N-1:0] req, input logic low, input logic clr);
        logic [N-1:0] old_pend, nxt;
        old_pend = m_pend;
        nxt = old_pend | (req & ~exp_valve());
        if (m_flush >= 0) begin
            m_left--;
            if (m_left == 0) begin
                m_flush = -1;
                if (low) begin m_refill = 1; m_age = 0; end
            end
        end else if (m_refill != 0) begin
            if (!low) m_refill = 0;
            else begin
                m_age++;
                if (m_age == TO) begin m_refill = 0; m_fault = 1; end
            end
        end else if (m_fault != 0) begin
            if (clr) m_fault = 0;
        end else if (low) begin
            m_refill = 1; m_age = 0;
        end else if (old_pend != '0) begin
            for (int k = 1; k <= N; k++) begin
                if (old_pend[(m_rr + k) % N]) begin
                    m_flush = (m_rr + k) % N;
                    break;
                end
            end
            m_rr = m_flush; m_grant = m_flush; m_left = FC; m_grants++;
            nxt = nxt & ~onehot(m_flush);
        end
        m_pend = nxt;
    endtask

    // Called just after a falling edge; returns just after the following falling edge.
    task automatic drive(input logic [N-1:0] req, input logic low, input logic clr);
        bus.flush_req = req; bus.tank_low = low; bus.fault_clr = clr;
        @(posedge clk);
        model_step(req, low, clr);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.flush_req = '0; bus.tank_low = 1'b0; bus.fault_clr = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.valve_open !== '0 || bus.pending !== '0 || bus.grant_id !== '0 ||
            bus.refill_pump !== 1'b0 || bus.busy !== 1'b0 || bus.owner_alert !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valve=%b pend=%b gid=%0d pump=%b busy=%b alert=%b expected all 0",
                     bus.valve_open, bus.pending, bus.grant_id, bus.refill_pump, bus.busy,
                     bus.owner_alert);
        end
    endtask

    task automatic test_single();
        logic [N-1:0] ev;
        do_reset();
        drive(4'b0100, 1'b0, 1'b0);
        checks++;
        if (bus.pending !== 4'b0100 || bus.valve_open !== 4'b0000) begin
            errors++;
            $display("FAIL single_capture: got pend=%b valve=%b expected pend=0100 valve=0000",
                     bus.pending, bus.valve_open);
        end
        for (int c = 2; c <= 10; c++) begin
            drive('0, 1'b0, 1'b0);
            ev = (c <= 9) ? 4'b0100 : 4'b0000;
            checks++;
            if (bus.valve_open !== ev) begin
                errors++;
                $display("FAIL single_valve c%0d: got %b expected %b", c, bus.valve_open, ev);
            end
            if (c == 2) begin
                checks++;
                if (bus.grant_id !== 2'd2 || bus.pending !== 4'b0000) begin
                    errors++;
                    $display("FAIL single_grant: got gid=%0d pend=%b expected gid=2 pend=0000",
                             bus.grant_id, bus.pending);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int starts[$];
        int ids[$];
        int open_cycles;
        logic [N-1:0] prev;
        do_reset();
        open_cycles = 0;
        prev = '0;
        drive(4'b1011, 1'b0, 1'b0);
        for (int c = 1; c <= 40; c++) begin
            drive('0, 1'b0, 1'b0);
            checks++;
            if (bus.valve_open !== exp_valve()) begin
                errors++;
                $display("FAIL b2b_valve c%0d: got %b expected %b", c, bus.valve_open, exp_valve());
            end
            if (bus.valve_open != '0) open_cycles++;
            if (bus.valve_open != '0 && prev == '0) begin
                starts.push_back(c);
                for (int s = 0; s < N; s++) if (bus.valve_open[s]) ids.push_back(s);
            end
            prev = bus.valve_open;
        end
        checks++;
        if (ids.size() != 3 || starts.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d grants expected 3", ids.size());
        end else begin
            if (ids[0] != 0 || ids[1] != 1 || ids[2] != 3) begin
                errors++;
                $display("FAIL b2b_order: got %0d,%0d,%0d expected 0,1,3", ids[0], ids[1], ids[2]);
            end
            checks++;
            if (starts[1] - starts[0] != FC + 1 || starts[2] - starts[1] != FC + 1 ||
                open_cycles != 3 * FC) begin
                errors++;
                $display("FAIL b2b_spacing: got starts %0d,%0d,%0d open=%0d expected spacing %0d open=%0d",
                         starts[0], starts[1], starts[2], open_cycles, FC + 1, 3 * FC);
            end
        end
    endtask

    task automatic test_refill_priority();
        int last_pump, first_s2, s1_cycles;
        do_reset();
        last_pump = -1; first_s2 = -1; s1_cycles = 0;
        drive(4'b0010, 1'b0, 1'b0);
        for (int c = 1; c <= 60; c++) begin
            drive((c == 3) ? 4'b0100 : 4'b0000, (c >= 3 && c <= 20), 1'b0);
            checks++;
            if (bus.valve_open !== exp_valve() || bus.refill_pump !== (m_refill != 0) ||
                bus.pending !== m_pend) begin
                errors++;
                $display("FAIL refill_model c%0d: got valve=%b pump=%b pend=%b expected %b %0d %b",
                         c, bus.valve_open, bus.refill_pump, bus.pending, exp_valve(), m_refill,
                         m_pend);
            end
            if (bus.valve_open[1]) s1_cycles++;
            if (bus.refill_pump) last_pump = c;
            if (bus.valve_open[2] && first_s2 < 0) first_s2 = c;
        end
        checks++;
        if (s1_cycles != FC) begin
            errors++;
            $display("FAIL refill_flush_len: got %0d expected %0d", s1_cycles, FC);
        end
        checks++;
        if (first_s2 < 0 || last_pump < 0 || first_s2 <= last_pump) begin
            errors++;
            $display("FAIL refill_order: got stall2 start %0d last pump %0d expected start after pump",
                     first_s2, last_pump);
        end
    endtask

    task automatic test_timeout();
        int pump_cycles;
        do_reset();
        pump_cycles = 0;
        for (int c = 0; c < 100 && bus.owner_alert !== 1'b1; c++) begin
            drive('0, 1'b1, 1'b0);
            if (bus.refill_pump) pump_cycles++;
        end
        checks++;
        if (bus.owner_alert !== 1'b1 || bus.refill_pump !== 1'b0 || pump_cycles != TO) begin
            errors++;
            $display("FAIL timeout_fault: got alert=%b pump=%b pump_cycles=%0d expected 1 0 %0d",
                     bus.owner_alert, bus.refill_pump, pump_cycles, TO);
        end
        drive(4'b0001, 1'b1, 1'b0);
        checks++;
        if (bus.owner_alert !== 1'b1 || bus.pending !== 4'b0001) begin
            errors++;
            $display("FAIL fault_capture: got alert=%b pend=%b expected 1 0001",
                     bus.owner_alert, bus.pending);
        end
        drive('0, 1'b1, 1'b1);
        checks++;
        if (bus.owner_alert !== 1'b0 || bus.refill_pump !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL fault_clear: got alert=%b pump=%b busy=%b expected 0 0 0",
                     bus.owner_alert, bus.refill_pump, bus.busy);
        end
        drive('0, 1'b1, 1'b0);
        checks++;
        if (bus.refill_pump !== 1'b1 || bus.valve_open !== 4'b0000) begin
            errors++;
            $display("FAIL refill_again: got pump=%b valve=%b expected 1 0000",
                     bus.refill_pump, bus.valve_open);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(4'b1100, 1'b0, 1'b0);
        drive('0, 1'b0, 1'b0);
        drive('0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.valve_open !== '0 || bus.pending !== '0 || bus.grant_id !== '0 ||
            bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got valve=%b pend=%b gid=%0d busy=%b expected all 0",
                     bus.valve_open, bus.pending, bus.grant_id, bus.busy);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(4'b1001, 1'b0, 1'b0);
        drive('0, 1'b0, 1'b0);
        checks++;
        if (bus.grant_id !== 2'd0 || bus.valve_open !== 4'b0001) begin
            errors++;
            $display("FAIL post_reset_grant: got gid=%0d valve=%b expected 0 0001",
                     bus.grant_id, bus.valve_open);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] req;
        logic low, clr;
        do_reset();
        low = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            req = ($urandom_range(0, 5) == 0) ? N'($urandom_range(0, 15)) : '0;
            if ($urandom_range(0, 24) == 0) low = ~low;
            clr = ($urandom_range(0, 9) == 0);
            drive(req, low, clr);
            checks++;
            if (bus.valve_open !== exp_valve() || bus.pending !== m_pend ||
                bus.grant_id !== 2'(m_grant) || bus.refill_pump !== (m_refill != 0) ||
                bus.busy !== (m_flush >= 0 || m_refill != 0) ||
                bus.owner_alert !== (m_fault != 0)) begin
                errors++;
                $display("FAIL random c%0d: got valve=%b pend=%b gid=%0d pump=%b busy=%b alert=%b expected %b %b %0d %0d %0d %0d",
                         c, bus.valve_open, bus.pending, bus.grant_id, bus.refill_pump, bus.busy,
                         bus.owner_alert, exp_valve(), m_pend, m_grant, m_refill,
                         (m_flush >= 0 || m_refill != 0), m_fault);
            end
            checks++;
            if ($countones(bus.valve_open) > 1 || (bus.valve_open != '0 && bus.refill_pump)) begin
                errors++;
                $display("FAIL invariant c%0d: got valve=%b pump=%b expected onehot0 and exclusive",
                         c, bus.valve_open, bus.refill_pump);
            end
        end
`ifdef FLUSH_SCHED_STATS_EN
        checks++;
        if (bus.flush_count !== 16'(m_grants)) begin
            errors++;
            $display("FAIL flush_count: got %0d expected %0d", bus.flush_count, m_grants);
        end
`endif
    endtask

    initial begin
        bus.flush_req = '0; bus.tank_low = 1'b0; bus.fault_clr = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_refill_priority();
        test_timeout();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1);
    end
endmodule
